// File: rtl/tt_um_kharar_divider.sv
// 8-bit restoring divider: load a divisor, start with a dividend, and read the
// quotient or remainder once done is set. Control pins are synchronized on entry.
module tt_um_kharar_divider (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t     state;
  logic [2:0] start_sync;  // [0] first flop, [1] second flop, [2] history
  logic [2:0] load_sync;
  logic [7:0] divisor;
  logic [7:0] dividend;
  logic [7:0] work_rem;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic [2:0] count;
  logic       busy;
  logic       done;
  logic       div0;

  logic       start_edge;
  logic       load_edge;
  logic [8:0] shifted;
  logic [8:0] diff;
  logic       fits;
  logic [7:0] next_rem;
  logic [7:0] next_dvd;

  assign start_edge = start_sync[1] & ~start_sync[2];
  assign load_edge  = load_sync[1] & ~load_sync[2];

  // One restoring step; rem < divisor before the shift keeps diff within 8 bits.
  always_comb begin
    shifted  = {work_rem, dividend[7]};
    fits     = (shifted >= {1'b0, divisor});
    diff     = shifted - {1'b0, divisor};
    next_rem = fits ? diff[7:0] : shifted[7:0];
    next_dvd = {dividend[6:0], fits};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      start_sync <= 3'b000;
      load_sync  <= 3'b000;
      divisor    <= 8'h00;
      dividend   <= 8'h00;
      work_rem   <= 8'h00;
      quotient   <= 8'h00;
      remainder  <= 8'h00;
      count      <= 3'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      div0       <= 1'b0;
    end else begin
      start_sync <= {start_sync[1:0], uio_in[0]};
      load_sync  <= {load_sync[1:0], uio_in[2]};
      unique case (state)
        StIdle, StDone: begin
          // A load wins over a coincident start.
          if (load_edge) begin
            divisor <= ui_in;
          end else if (start_edge) begin
            dividend <= ui_in;
            if (divisor == 8'h00) begin
              quotient  <= 8'hFF;
              remainder <= ui_in;
              div0      <= 1'b1;
              done      <= 1'b1;
              state     <= StDone;
            end else begin
              work_rem <= 8'h00;
              count    <= 3'd0;
              busy     <= 1'b1;
              done     <= 1'b0;
              div0     <= 1'b0;
              state    <= StRun;
            end
          end
        end
        StRun: begin
          work_rem <= next_rem;
          dividend <= next_dvd;
          count    <= count + 3'd1;
          if (count == 3'd7) begin
            quotient  <= next_dvd;
            remainder <= next_rem;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= StDone;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign uo_out  = uio_in[1] ? remainder : quotient;
  assign uio_out = {1'b0, div0, done, busy, 4'b0000};
  assign uio_oe  = 8'hF0;

  logic unused;
  assign unused = &{1'b0, ena, uio_in[7:3], diff[8]};

endmodule

// File: tb/tb_tt_um_kharar_divider.sv
// Scoreboard bench for the divider: stimulus pushes expected results computed
// with plain integer division, a monitor pops them whenever a result appears.
module tb_tt_um_kharar_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic       start_pin = 1'b0;
  logic       sel_pin = 1'b0;
  logic       load_pin = 1'b0;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  assign uio_in = {5'b00000, load_pin, sel_pin, start_pin};

  tt_um_kharar_divider dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    bit         z;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] model_div = 8'h00;
  logic [7:0] prev_q = 8'h00;
  bit         last_z = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a fresh result is flagged by done or div0 rising.
  initial begin : monitor
    logic pd, pz;
    exp_t e;
    pd = 1'b0;
    pz = 1'b0;
    forever begin
      @(negedge clk);
      if ((uio_out[5] && !pd) || (uio_out[6] && !pz)) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          sel_pin = 1'b0;
          #1 chk("quotient", uo_out, e.q);
          sel_pin = 1'b1;
          #1 chk("remainder", uo_out, e.r);
          chk("div0_flag", uio_out[6], e.z);
          sel_pin = 1'b0;
        end
      end
      pd = uio_out[5];
      pz = uio_out[6];
    end
  end

  task automatic do_load(input logic [7:0] v);
    @(negedge clk);
    ui_in    = v;
    load_pin = 1'b1;
    repeat (2) @(negedge clk);
    load_pin = 1'b0;
    repeat (3) @(negedge clk);
    model_div = v;
  endtask

  // Start an operation; checks busy/done cycle by cycle (k = edges after E0).
  task automatic do_start(input logic [7:0] dvd, input bit inject, input bit rst_mid);
    bit   z;
    logic pdone;
    exp_t e;
    z     = (model_div == 8'h00);
    pdone = uio_out[5];
    @(negedge clk);
    ui_in     = dvd;
    start_pin = 1'b1;
    e.z = z;
    e.q = z ? 8'hFF : 8'(dvd / model_div);
    e.r = z ? dvd : 8'(dvd % model_div);
    if (!rst_mid) sb.push_back(e);
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk);
      if (k == 2) start_pin = 1'b0;
      if (inject && k == 4) begin
        start_pin = 1'b1;
        load_pin  = 1'b1;
        ui_in     = 8'd3;
      end
      if (inject && k == 6) begin
        start_pin = 1'b0;
        load_pin  = 1'b0;
        ui_in     = dvd;
      end
      chk("busy", uio_out[4], (!z && k >= 2 && k <= 9) ? 1 : 0);
      chk("done", uio_out[5], (k < 2) ? int'(pdone) : ((z || k >= 10) ? 1 : 0));
      if (!z && k >= 3 && k <= 9) chk("stable_during_run", uo_out, prev_q);
      if (rst_mid && k == 5) begin
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_uo_out", uo_out, 0);
        chk("rst_uio_out", uio_out, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        model_div = 8'h00;
        prev_q    = 8'h00;
        last_z    = 1'b0;
        repeat (3) @(negedge clk);
        return;
      end
    end
    prev_q = e.q;
    last_z = z;
  endtask

  // Coincident load and start: the load applies and no run begins.
  task automatic do_load_start(input logic [7:0] v);
    logic pdone;
    pdone = uio_out[5];
    @(negedge clk);
    ui_in     = v;
    load_pin  = 1'b1;
    start_pin = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k == 2) begin
        load_pin  = 1'b0;
        start_pin = 1'b0;
      end
      chk("ls_busy", uio_out[4], 0);
      chk("ls_done", uio_out[5], pdone);
    end
    model_div = v;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [7:0] d;
    logic [7:0] a;
    repeat (3) @(negedge clk);
    chk("reset_uo_out", uo_out, 0);
    chk("reset_uio_out", uio_out, 0);
    chk("uio_oe", uio_oe, 8'hF0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_start(8'd77, 1'b0, 1'b0);     // no load after reset -> divide by zero
    do_load(8'd7);
    do_start(8'd100, 1'b0, 1'b0);
    do_load(8'd0);
    do_start(8'd55, 1'b0, 1'b0);
    do_load(8'd1);
    do_start(8'd255, 1'b0, 1'b0);
    do_load(8'd200);
    do_start(8'd5, 1'b0, 1'b0);
    do_load(8'd255);
    do_start(8'd255, 1'b0, 1'b0);
    do_load(8'd9);
    do_start(8'd0, 1'b0, 1'b0);

    do_load(8'd7);
    do_start(8'd100, 1'b1, 1'b0);    // start + load 3 injected mid-run
    do_start(8'd100, 1'b0, 1'b0);    // divisor must still be 7

    do_load_start(8'd9);
    do_start(8'd90, 1'b0, 1'b0);

    do_load(8'd7);
    do_start(8'd100, 1'b0, 1'b1);    // reset at E6
    do_load(8'd7);
    do_start(8'd100, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom_range(0, 255));
      if (d == 8'h00 && last_z) d = 8'd1;
      a = 8'($urandom_range(0, 255));
      do_load(d);
      do_start(a, 1'b0, 1'b0);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
